// File: rtl/bincnt_pkg.sv
// Shared types and helpers for the sequential popcount.
// Slice width, FSM states and thermometer decode.
package bincnt_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // y[3] fills first; the lowest set bit gives the count
  function automatic logic [2:0] thermo4_to_cnt(
    input logic [3:0] y
  );
    logic [2:0] c;
    c = 3'd0;
    unique case (1'b1)
      y[0]:                 c = 3'd4;
      y[1] & ~y[0]:         c = 3'd3;
      y[2] & ~y[1] & ~y[0]: c = 3'd2;
      y[3] & ~y[2] & ~y[1] & ~y[0]:
                            c = 3'd1;
      default:              c = 3'd0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/bincnt_seq_sorter4b.sv
// 4-input bit sorter; ones gather toward y[3].
// Three-layer compare-exchange network on single bits.
module sorter4b (
  input  logic [3:0] a,
  output logic [3:0] y
);

  logic h01, l01, h23, l23;
  logic top, m1, m2, bot;

  // OR is max, AND is min for single bits
  always_comb begin
    h01  = a[0] | a[1];
    l01  = a[0] & a[1];
    h23  = a[2] | a[3];
    l23  = a[2] & a[3];
    top  = h01 | h23;
    m1   = h01 & h23;
    m2   = l01 | l23;
    bot  = l01 & l23;
    y[3] = top;
    y[2] = m1 | m2;
    y[1] = m1 & m2;
    y[0] = bot;
  end

endmodule

// File: rtl/bincnt_seq.sv
// Sequential popcount: one sorter4b reused per slice.
// Word in via valid/ready, count out via valid/ready.
module bincnt_seq
  import bincnt_pkg::*;
#(
  parameter  int WIDTH = 16,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    out_count,
  output logic             busy
);

  localparam int NSLICE = WIDTH / SLICE_W;
  localparam int IW =
    (NSLICE > 1) ? $clog2(NSLICE) : 1;

  if (WIDTH < SLICE_W || (WIDTH % SLICE_W) != 0)
  begin : g_bad_width
    $error("bincnt_seq: WIDTH must be a multiple of 4, >= 4");
  end

  state_t           state_q, state_d;
  logic [CW-1:0]    acc;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] shreg;
  logic [3:0]       y;
  logic [2:0]       cnt;
  logic             last;
  logic             load;

  sorter4b u_sort (
    .a (shreg[SLICE_W-1:0]),
    .y (y)
  );

  assign cnt  = thermo4_to_cnt(y);
  assign last = (idx == IW'(NSLICE - 1));
  assign load = in_valid && in_ready;

  // state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // next state and handshake outputs
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_d = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // slice shifter, index and accumulator
  always_ff @(posedge clk) begin
    if (rst) begin
      acc   <= '0;
      idx   <= '0;
      shreg <= '0;
    end else if (state_q == IDLE) begin
      if (load) begin
        shreg <= in_data;
        acc   <= '0;
        idx   <= '0;
      end
    end else if (state_q == RUN) begin
      acc   <= acc + CW'(cnt);
      shreg <= shreg >> SLICE_W;
      idx   <= idx + 1'b1;
    end
  end

  assign out_count = acc;

  // sorter must emit a thermometer code
  always_ff @(posedge clk) begin
    if (!rst && state_q == RUN) begin
      a_thermo: assert (y[3] >= y[2] &&
                        y[2] >= y[1] &&
                        y[1] >= y[0]);
    end
  end

endmodule

// File: tb/tb_bincnt_seq.sv
// Directed and random checks for bincnt_seq.
// Covers WIDTH 16, 4 and 12.
module tb_bincnt_seq;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [4:0]  out_count;
  logic        busy;

  logic        d4_iv = 1'b0;
  logic        d4_ir;
  logic [3:0]  d4_id = '0;
  logic        d4_ov;
  logic        d4_or = 1'b0;
  logic [2:0]  d4_oc;
  logic        d4_busy;

  logic        d12_iv = 1'b0;
  logic        d12_ir;
  logic [11:0] d12_id = '0;
  logic        d12_ov;
  logic        d12_or = 1'b0;
  logic [3:0]  d12_oc;
  logic        d12_busy;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bincnt_seq #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_count (out_count),
    .busy      (busy)
  );

  bincnt_seq #(.WIDTH(4)) dut4 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (d4_iv),
    .in_ready  (d4_ir),
    .in_data   (d4_id),
    .out_valid (d4_ov),
    .out_ready (d4_or),
    .out_count (d4_oc),
    .busy      (d4_busy)
  );

  bincnt_seq #(.WIDTH(12)) dut12 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (d12_iv),
    .in_ready  (d12_ir),
    .in_data   (d12_id),
    .out_valid (d12_ov),
    .out_ready (d12_or),
    .out_count (d12_oc),
    .busy      (d12_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  task automatic run_word(input logic [15:0] w,
                          input logic [4:0] exp,
                          input int bp,
                          input bit scramble);
    int n;
    in_data  = w;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    chk("accept_ready", 32'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      if (scramble) in_data = 16'($urandom);
      tick();
      n++;
    end
    chk("latency", n, 4);
    for (int k = 0; k < bp; k++) begin
      out_ready = 1'b0;
      chk("bp_count", 32'(out_count), 32'(exp));
      chk("bp_valid", 32'(out_valid), 1);
      tick();
    end
    out_ready = 1'b1;
    chk("count", 32'(out_count), 32'(exp));
    tick();
    out_ready = 1'b0;
    chk("idle_ready", 32'(in_ready), 1);
    chk("idle_valid", 32'(out_valid), 0);
    chk("idle_busy", 32'(busy), 0);
  endtask

  logic [15:0] bw [3];
  logic [4:0]  be [3];

  initial begin
    int n;
    int i;
    int j;
    int cyc;
    int last_acc;
    bit take;
    logic [15:0] rw;

    // reset with a pending word: nothing is taken
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = 16'hFFFF;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rst_in_ready", 32'(in_ready), 1);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_out_count", 32'(out_count), 0);
      chk("rst_busy", 32'(busy), 0);
    end
    in_valid = 1'b0;
    rst      = 1'b0;
    tick();
    chk("post_rst_busy", 32'(busy), 0);

    run_word(16'h0000, 5'd0, 0, 0);
    run_word(16'hFFFF, 5'd16, 0, 0);
    run_word(16'hA5C3, 5'd8, 0, 0);
    run_word(16'h0001, 5'd1, 0, 0);

    // backpressure plus input churn during RUN
    run_word(16'h7E01, 5'd7, 10, 1);

    // abort mid-RUN at idx 2
    in_data  = 16'hFFFF;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("midrun_busy", 32'(busy), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrun_rst_busy", 32'(busy), 0);
    chk("midrun_rst_count", 32'(out_count), 0);
    run_word(16'h000F, 5'd4, 0, 0);

    // reset while holding a result
    in_data  = 16'h00FF;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    chk("done_valid", 32'(out_valid), 1);
    chk("done_count", 32'(out_count), 8);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("done_rst_valid", 32'(out_valid), 0);
    chk("done_rst_ready", 32'(in_ready), 1);

    // back-to-back with in_valid and out_ready held
    bw[0] = 16'h1111; be[0] = 5'd4;
    bw[1] = 16'h8000; be[1] = 5'd1;
    bw[2] = 16'hF0F0; be[2] = 5'd8;
    in_data   = bw[0];
    in_valid  = 1'b1;
    out_ready = 1'b1;
    i = 0;
    j = 0;
    cyc = 0;
    last_acc = -1;
    for (int t = 0; t < 40 && j < 3; t++) begin
      if (out_valid) begin
        chk("b2b_count", 32'(out_count), 32'(be[j]));
        j++;
      end
      take = in_valid && in_ready;
      tick();
      cyc++;
      if (take) begin
        if (last_acc >= 0)
          chk("b2b_gap", cyc - last_acc, 6);
        last_acc = cyc;
        i++;
        if (i < 3) in_data = bw[i];
        else       in_valid = 1'b0;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("b2b_results", j, 3);
    chk("b2b_accepts", i, 3);

    // WIDTH=4: one slice
    d4_id = 4'hB;
    d4_iv = 1'b1;
    chk("w4_ready", 32'(d4_ir), 1);
    tick();
    d4_iv = 1'b0;
    n = 0;
    while (!d4_ov && n < 20) begin
      tick();
      n++;
    end
    chk("w4_latency", n, 1);
    chk("w4_count", 32'(d4_oc), 3);
    d4_or = 1'b1;
    tick();
    d4_or = 1'b0;
    chk("w4_idle", 32'(d4_ir), 1);

    // WIDTH=12: three slices
    d12_id = 12'hFFF;
    d12_iv = 1'b1;
    chk("w12_ready", 32'(d12_ir), 1);
    tick();
    d12_iv = 1'b0;
    n = 0;
    while (!d12_ov && n < 20) begin
      tick();
      n++;
    end
    chk("w12_latency", n, 3);
    chk("w12_count", 32'(d12_oc), 12);
    d12_or = 1'b1;
    tick();
    d12_or = 1'b0;
    chk("w12_idle", 32'(d12_ir), 1);

    // random words against a reference popcount
    for (int k = 0; k < 1000; k++) begin
      rw = 16'($urandom);
      run_word(rw, 5'($countones(rw)), k % 3, k[0]);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
